// File: rtl/njp_micro_pkg.sv
// Shared types and constants for the micro-multiplier output stage.
// Revision: 1.0
`default_nettype none
package njp_micro_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int DEF_IN_W    = 8;
  localparam int DEF_DIGITS  = 3;

  // Counter must be able to hold IN_W itself, not just IN_W-1.
  function automatic int cnt_width(input int in_w);
    return $clog2(in_w + 1);
  endfunction
endpackage
`default_nettype wire

// File: rtl/njp_product_bcd_if.sv
// Product-in / BCD-out valid-ready bus of the conversion stage.
// Revision: 1.0
`default_nettype none
interface njp_product_bcd_if #(
  parameter int IN_W   = njp_micro_pkg::DEF_IN_W,
  parameter int DIGITS = njp_micro_pkg::DEF_DIGITS
);
  logic                          prod_valid;
  logic [IN_W-1:0]               prod_in;
  logic                          prod_ready;
  logic                          bcd_valid;
  logic                          bcd_ready;
  logic [4*DIGITS-1:0]           bcd_out;
  logic                          busy;

  modport master (
    output prod_valid, prod_in, bcd_ready,
    input  prod_ready, bcd_valid, bcd_out, busy
  );

  modport slave (
    input  prod_valid, prod_in, bcd_ready,
    output prod_ready, bcd_valid, bcd_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/njp_dabble_cell.sv
// One double-dabble digit correction: digits of 5 or more get +3 before the shift.
// Revision: 1.0
`default_nettype none
module njp_dabble_cell (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);
  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
endmodule
`default_nettype wire

// File: rtl/njp_product_bcd.sv
// Sequential binary-to-packed-BCD converter with valid/ready on both sides.
// Revision: 1.0
`default_nettype none
module njp_product_bcd
  import njp_micro_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  njp_product_bcd_if.slave    bus
);
  localparam int CNT_W = cnt_width(IN_W);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  if ((10 ** DIGITS) <= ((2 ** IN_W) - 1)) begin : g_digits_check
    $error("njp_product_bcd: DIGITS too small for IN_W");
  end

  state_t             state, state_nxt;
  logic [IN_W-1:0]    bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shifted;
  logic [BCD_W-1:0]   out_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_shift;

  for (genvar d = 0; d < DIGITS; d++) begin : g_cell
    njp_dabble_cell u_cell (
      .digit_in  (bcd_q  [d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (bcd_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected digits shifted left with the binary MSB entering the ones digit.
  assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_q[IN_W-1]};
  assign last_shift  = (cnt_q == CNT_W'(1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.prod_valid) state_nxt = SHIFT;
      SHIFT:   if (last_shift)     state_nxt = DONE;
      DONE:    if (bus.bcd_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.prod_valid) begin
            bin_q <= bus.prod_in;
            bcd_q <= '0;
            cnt_q <= CNT_W'(IN_W);
          end
        end
        SHIFT: begin
          bcd_q <= bcd_shifted;
          bin_q <= {bin_q[IN_W-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
          // Result register only moves on entry to DONE; holds through backpressure and after.
          if (last_shift) out_q <= bcd_shifted;
        end
        default: ;
      endcase
    end
  end

  assign bus.prod_ready = (state == IDLE);
  assign bus.bcd_valid  = (state == DONE);
  assign bus.busy       = (state == SHIFT);
  assign bus.bcd_out    = out_q;
endmodule
`default_nettype wire
